// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the pong game controller: FSM state encodings, screen
// extents, default game parameters and the BCD score type with its increment helper.
package pong_game_ctrl_pkg;

  localparam int unsigned MAX_X           = 640;
  localparam int unsigned MAX_Y           = 480;
  localparam int unsigned DEF_BALLS       = 3;
  localparam int unsigned DEF_DELAY_TICKS = 120;

  // Encodings are visible to the text overlay through state_o.
  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_e;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d0;
  } score_t;

  localparam score_t SCORE_ZERO = '{d1: 4'd0, d0: 4'd0};

  function automatic logic score_is_max(input score_t s);
    return (s.d1 == 4'd9) && (s.d0 == 4'd9);
  endfunction

  // Two-digit BCD increment that holds at 99.
  function automatic score_t bcd_inc(input score_t s);
    score_t r;
    r = s;
    if (!score_is_max(s)) begin
      if (s.d0 == 4'd9) begin
        r.d0 = 4'd0;
        r.d1 = s.d1 + 4'd1;
      end else begin
        r.d0 = s.d0 + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_round_timer.sv
// Inter-round delay timer: loads LOAD_VAL, counts down once per refresh tick and
// holds at zero; a load takes priority over a decrement.
module pong_round_timer #(
  parameter int unsigned LOAD_VAL = 120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic zero
);

  localparam int unsigned W = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(LOAD_VAL);
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-sequencing FSM: new-game/play/new-ball/game-over flow, BCD score,
// ball counter and button edge detect. Optional speed-up levels under PONG_SPEEDUP_EN.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned BALLS       = DEF_BALLS,
  parameter int unsigned DELAY_TICKS = DEF_DELAY_TICKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic       hit,
  input  logic       miss,
  input  logic       refresh_tick,
  output logic       gra_still,
  output logic [1:0] state_o,
  output logic [1:0] balls_left,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] speed_lvl
);

  localparam logic [1:0] BALLS_RST   = 2'(BALLS);
  localparam logic [1:0] BALLS_START = 2'(BALLS - 1);

  state_e state;
  score_t score;
  logic   btn_any;
  logic   btn_prev;
  logic   btn_armed;
  logic   press;
  logic   timer_load;
  logic   timer_zero;

  // A button held through reset must be released once before it can count,
  // so the edge detector is only armed after an all-released cycle.
  assign btn_any = |{btn1, btn2};
  assign press   = btn_any && !btn_prev && btn_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev  <= 1'b0;
      btn_armed <= 1'b0;
    end else begin
      btn_prev  <= btn_any;
      btn_armed <= btn_armed || !btn_any;
    end
  end

  assign timer_load = (state == ST_PLAY) && miss;

  pong_round_timer #(
    .LOAD_VAL(DELAY_TICKS)
  ) u_round_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .tick (refresh_tick),
    .zero (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_NEWGAME;
      gra_still  <= 1'b1;
      balls_left <= BALLS_RST;
      score      <= SCORE_ZERO;
    end else begin
      case (state)
        ST_NEWGAME: begin
          if (press) begin
            state      <= ST_PLAY;
            gra_still  <= 1'b0;
            score      <= SCORE_ZERO;
            balls_left <= BALLS_START;
          end
        end
        ST_PLAY: begin
          // A miss in the same cycle as a hit ends the rally; the hit is dropped.
          if (miss) begin
            gra_still <= 1'b1;
            if (balls_left == 2'd0) begin
              state <= ST_OVER;
            end else begin
              state      <= ST_NEWBALL;
              balls_left <= balls_left - 2'd1;
            end
          end else if (hit) begin
            score <= bcd_inc(score);
          end
        end
        ST_NEWBALL: begin
          if (press && timer_zero) begin
            state     <= ST_PLAY;
            gra_still <= 1'b0;
          end
        end
        ST_OVER: begin
          if (timer_zero) begin
            state <= ST_NEWGAME;
          end
        end
        default: begin
          state     <= ST_NEWGAME;
          gra_still <= 1'b1;
        end
      endcase
    end
  end

  assign state_o  = state;
  assign score_d1 = score.d1;
  assign score_d0 = score.d0;

`ifdef PONG_SPEEDUP_EN
  logic       game_start;
  logic       units_wrap;
  logic [1:0] speed_q;

  assign game_start = (state == ST_NEWGAME) && press;
  assign units_wrap = (state == ST_PLAY) && hit && !miss &&
                      (score.d0 == 4'd9) && !score_is_max(score);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= 2'd0;
    end else if (game_start) begin
      speed_q <= 2'd0;
    end else if (units_wrap && (speed_q != 2'd3)) begin
      speed_q <= speed_q + 2'd1;
    end
  end

  assign speed_lvl = speed_q;
`else
  assign speed_lvl = 2'b00;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus queues hand-computed expected outputs,
// a negedge monitor pops and compares them.
module tb_pong_game_ctrl;
  import pong_game_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn1 = 2'b00;
  logic [1:0] btn2 = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       refresh_tick = 1'b0;
  logic       gra_still;
  logic [1:0] state_o;
  logic [1:0] balls_left;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] speed_lvl;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn1        (btn1),
    .btn2        (btn2),
    .hit         (hit),
    .miss        (miss),
    .refresh_tick(refresh_tick),
    .gra_still   (gra_still),
    .state_o     (state_o),
    .balls_left  (balls_left),
    .score_d1    (score_d1),
    .score_d0    (score_d0),
    .speed_lvl   (speed_lvl)
  );

`ifdef PONG_SPEEDUP_EN
  localparam bit SPD_EN = 1'b1;
`else
  localparam bit SPD_EN = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       still;
    logic [1:0] balls;
    bit         chk_balls;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [1:0] spd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  function automatic logic [1:0] spd(input logic [1:0] n);
    return SPD_EN ? n : 2'd0;
  endfunction

  task automatic push_exp(input string name, input logic [1:0] st, input logic still,
                          input logic [1:0] balls, input bit chk_balls,
                          input logic [3:0] d1, input logic [3:0] d0, input logic [1:0] sp);
    exp_t e;
    e.name = name; e.st = st; e.still = still; e.balls = balls;
    e.chk_balls = chk_balls; e.d1 = d1; e.d0 = d0; e.spd = sp;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if (state_o !== mon_e.st || gra_still !== mon_e.still ||
          (mon_e.chk_balls && balls_left !== mon_e.balls) ||
          score_d1 !== mon_e.d1 || score_d0 !== mon_e.d0 || speed_lvl !== mon_e.spd) begin
        bad++;
        $display("FAIL %s: got st=%0d still=%0d balls=%0d score=%0d%0d spd=%0d, want st=%0d still=%0d balls=%0d%s score=%0d%0d spd=%0d",
                 mon_e.name, state_o, gra_still, balls_left, score_d1, score_d0, speed_lvl,
                 mon_e.st, mon_e.still, mon_e.balls, mon_e.chk_balls ? "" : "(any)",
                 mon_e.d1, mon_e.d0, mon_e.spd);
      end
    end
  end

  task automatic step(input logic [1:0] b1, input logic [1:0] b2,
                      input logic h, input logic m, input logic t);
    @(negedge clk);
    #1;
    btn1 = b1; btn2 = b2; hit = h; miss = m; refresh_tick = t;
    @(posedge clk);
    #1;
    hit = 1'b0; miss = 1'b0; refresh_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(btn1, btn2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic release_btns();
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", ST_NEWGAME, 1'b1, 2'd3, 1'b1, 4'd0, 4'd0, 2'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    release_btns();
    release_btns();
    push_exp("idle_newgame", ST_NEWGAME, 1'b1, 2'd3, 1'b1, 4'd0, 4'd0, 2'd0);

    // Test 1: single-cycle press starts the game.
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    push_exp("t1_press_play", ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd0, 4'd0, 2'd0);
    release_btns();

    // Test 2: twelve hits, including the 9->10 carry.
    for (int i = 1; i <= 12; i++) begin
      step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      if (i == 9)  push_exp("t2_hit9",  ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd0, 4'd9, spd(2'd0));
      if (i == 10) push_exp("t2_hit10", ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd1, 4'd0, spd(2'd1));
      if (i == 12) push_exp("t2_hit12", ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd1, 4'd2, spd(2'd1));
    end

    // Test 3: miss, early presses ignored until the timer expires.
    step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push_exp("t3_miss", ST_NEWBALL, 1'b1, 2'd1, 1'b1, 4'd1, 4'd2, spd(2'd1));
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push_exp("t3_hit_ignored", ST_NEWBALL, 1'b1, 2'd1, 1'b1, 4'd1, 4'd2, spd(2'd1));
    ticks(49);
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    push_exp("t3_press_tick50", ST_NEWBALL, 1'b1, 2'd1, 1'b1, 4'd1, 4'd2, spd(2'd1));
    release_btns();
    ticks(69);
    step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    push_exp("t3_press_timer1", ST_NEWBALL, 1'b1, 2'd1, 1'b1, 4'd1, 4'd2, spd(2'd1));
    release_btns();
    ticks(1);
    step(2'b00, 2'b01, 1'b0, 1'b0, 1'b1);
    push_exp("t3_press_tick121", ST_PLAY, 1'b0, 2'd1, 1'b1, 4'd1, 4'd2, spd(2'd1));
    release_btns();

    // Test 4: remaining balls lost, game over, automatic return to NEWGAME.
    step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push_exp("t4_miss2", ST_NEWBALL, 1'b1, 2'd0, 1'b1, 4'd1, 4'd2, spd(2'd1));
    ticks(120);
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    push_exp("t4_round3", ST_PLAY, 1'b0, 2'd0, 1'b1, 4'd1, 4'd2, spd(2'd1));
    release_btns();
    step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push_exp("t4_miss3_over", ST_OVER, 1'b1, 2'd0, 1'b1, 4'd1, 4'd2, spd(2'd1));
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    push_exp("t4_over_btn_ignored", ST_OVER, 1'b1, 2'd0, 1'b1, 4'd1, 4'd2, spd(2'd1));
    release_btns();
    ticks(119);
    push_exp("t4_over_tick119", ST_OVER, 1'b1, 2'd0, 1'b1, 4'd1, 4'd2, spd(2'd1));
    ticks(1);
    push_exp("t4_over_tick120", ST_OVER, 1'b1, 2'd0, 1'b1, 4'd1, 4'd2, spd(2'd1));
    release_btns();
    push_exp("t4_newgame_score_held", ST_NEWGAME, 1'b1, 2'd0, 1'b0, 4'd1, 4'd2, spd(2'd1));
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    push_exp("t4_new_game_clear", ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd0, 4'd0, 2'd0);
    release_btns();

    // Test 5: hit and miss together, miss wins.
    repeat (5) step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push_exp("t5_score05", ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd0, 4'd5, 2'd0);
    step(2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    push_exp("t5_hit_miss", ST_NEWBALL, 1'b1, 2'd1, 1'b1, 4'd0, 4'd5, 2'd0);
    ticks(120);
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    push_exp("t5_resume", ST_PLAY, 1'b0, 2'd1, 1'b1, 4'd0, 4'd5, 2'd0);
    release_btns();

    // Test 6: asynchronous reset mid-play with a button held through it.
    repeat (32) step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push_exp("t6_score37", ST_PLAY, 1'b0, 2'd1, 1'b1, 4'd3, 4'd7, spd(2'd3));
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    push_exp("t6_async_reset", ST_NEWGAME, 1'b1, 2'd3, 1'b1, 4'd0, 4'd0, 2'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    push_exp("t6_held_no_press", ST_NEWGAME, 1'b1, 2'd3, 1'b1, 4'd0, 4'd0, 2'd0);
    release_btns();
    push_exp("t6_released", ST_NEWGAME, 1'b1, 2'd3, 1'b1, 4'd0, 4'd0, 2'd0);
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    push_exp("t6_repress", ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd0, 4'd0, 2'd0);
    release_btns();

    // Score saturation at 99 and speed-level saturation at 3.
    for (int i = 1; i <= 101; i++) begin
      step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      if (i == 20)  push_exp("sat_hit20", ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd2, 4'd0, spd(2'd2));
      if (i == 40)  push_exp("sat_hit40", ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd4, 4'd0, spd(2'd3));
      if (i == 99)  push_exp("sat_hit99", ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd9, 4'd9, spd(2'd3));
      if (i == 101) push_exp("sat_hold",  ST_PLAY, 1'b0, 2'd2, 1'b1, 4'd9, 4'd9, spd(2'd3));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
